pcie_tx_cmd_arbiter: RTL and testbench



---
 rtl/pcie_tx_cmd_arbiter_if.sv | 26 ++
 rtl/pcie_tx_cmd_arbiter.sv | 119 +++++++++++
 tb/tb_pcie_tx_cmd_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_tx_cmd_arbiter_if.sv
// Requester/FIFO-side bundle of the PCIe TX command arbiter.
// slave = arbiter view, master = requesters plus FIFO status (testbench view).
interface pcie_tx_cmd_arbiter_if #(
    parameter int P_NUM_REQ    = 4,
    parameter int P_DATA_WIDTH = 46
);
    // req_valid[i] is held with its req_data until the single-cycle req_ack[i]; dropping it before grant withdraws.
    logic [P_NUM_REQ-1:0]                req_valid;
    logic [P_NUM_REQ*2*P_DATA_WIDTH-1:0] req_data;
    logic [P_NUM_REQ-1:0]                req_ack;
    logic                                fifo_wr_en;
    logic [P_DATA_WIDTH-1:0]             fifo_wr_data;
    logic                                fifo_full_n;
    logic                                busy;
    logic [1:0]                          state_dbg;

    modport master (
        output req_valid, req_data, fifo_full_n,
        input  req_ack, fifo_wr_en, fifo_wr_data, busy, state_dbg
    );

    modport slave (
        input  req_valid, req_data, fifo_full_n,
        output req_ack, fifo_wr_en, fifo_wr_data, busy, state_dbg
    );
endinterface

// File: rtl/pcie_tx_cmd_arbiter.sv
// Round-robin arbiter writing two-entry commands atomically into the PCIe TX command FIFO.
// Optional PCIE_TX_CMD_ARB_PRIO_EN gives requester 0 strict priority over the rotating rest.
module pcie_tx_cmd_arbiter #(
    parameter int P_NUM_REQ    = 4,
    parameter int P_DATA_WIDTH = 46
) (
    input  logic                   clk,
    input  logic                   rst,
    pcie_tx_cmd_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(P_NUM_REQ);
    localparam int CMD_W = 2 * P_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;

    logic             found;
    logic [IDX_W-1:0] pick;
    logic [IDX_W:0]   cand;

    // Search upward from rr_ptr; the extra bit of cand holds the unwrapped sum before the modulo.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
`ifdef PCIE_TX_CMD_ARB_PRIO_EN
        if (bus.req_valid[0]) begin
            found = 1'b1;
        end
`endif
        for (int k = 0; k < P_NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand > (IDX_W+1)'(P_NUM_REQ - 1)) begin
                cand = cand - (IDX_W+1)'(P_NUM_REQ);
            end
`ifdef PCIE_TX_CMD_ARB_PRIO_EN
            if (!found && (cand != '0) && bus.req_valid[cand[IDX_W-1:0]]) begin
`else
            if (!found && bus.req_valid[cand[IDX_W-1:0]]) begin
`endif
                found = 1'b1;
                pick  = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        cmd_d    = cmd_q;
        case (state_q)
            IDLE: begin
                if (bus.fifo_full_n && found) begin
                    grant_d = pick;
                    cmd_d   = bus.req_data[int'(pick)*CMD_W +: CMD_W];
                    state_d = WR_LO;
                end
            end
            WR_LO: state_d = WR_HI;
            WR_HI: begin
                state_d = IDLE;
`ifdef PCIE_TX_CMD_ARB_PRIO_EN
                // A priority grant leaves the rotation of requesters 1..N-1 where it was.
                if (grant_q != '0) begin
                    rr_ptr_d = (grant_q == IDX_W'(P_NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
`else
                rr_ptr_d = (grant_q == IDX_W'(P_NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cmd_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cmd_q    <= cmd_d;
        end
    end

    // Outputs decode registered state only, so requester inputs never reach the FIFO port combinationally.
    always_comb begin
        bus.fifo_wr_en   = 1'b0;
        bus.fifo_wr_data = '0;
        bus.req_ack      = '0;
        case (state_q)
            WR_LO: begin
                bus.fifo_wr_en   = 1'b1;
                bus.fifo_wr_data = cmd_q[P_DATA_WIDTH-1:0];
            end
            WR_HI: begin
                bus.fifo_wr_en   = 1'b1;
                bus.fifo_wr_data = cmd_q[CMD_W-1:P_DATA_WIDTH];
                bus.req_ack      = P_NUM_REQ'(1) << grant_q;
            end
            default: ;
        endcase
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_pcie_tx_cmd_arbiter.sv
// Self-checking bench for pcie_tx_cmd_arbiter: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_pcie_tx_cmd_arbiter;
    localparam int N = 4;
    localparam int W = 46;
`ifdef PCIE_TX_CMD_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    pcie_tx_cmd_arbiter_if #(.P_NUM_REQ(N), .P_DATA_WIDTH(W)) bus ();

    pcie_tx_cmd_arbiter #(.P_NUM_REQ(N), .P_DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] lo_d [N];
    logic [W-1:0] hi_d [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.req_data[i*2*W +: 2*W] = {hi_d[i], lo_d[i]};
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.req_valid   = '0;
        bus.fifo_full_n = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) for the low entry, then checks the pair and the ack of requester g.
    task automatic expect_cmd(input int g, input string name, output int lat);
        int t;
        t = 0;
        tick();
        while (!bus.fifo_wr_en && t < 6) begin
            tick();
            t++;
        end
        lat = t;
        check({name, " lo_en"},   64'(bus.fifo_wr_en),   64'(1));
        check({name, " lo_data"}, 64'(bus.fifo_wr_data), 64'(lo_d[g]));
        check({name, " lo_ack"},  64'(bus.req_ack),      64'(0));
        tick();
        check({name, " hi_en"},   64'(bus.fifo_wr_en),   64'(1));
        check({name, " hi_data"}, 64'(bus.fifo_wr_data), 64'(hi_d[g]));
        check({name, " hi_ack"},  64'(bus.req_ack),      64'(4'(1) << g));
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q[$];
    logic [N-1:0] ack_q[$];
    int           rr_m;
    logic [N-1:0] granted;
    logic         cur_en;
    logic [W-1:0] cur_data;
    logic [N-1:0] cur_ack;

    task automatic model_reset();
        exp_q.delete();
        ack_q.delete();
        rr_m     = 0;
        granted  = '0;
        cur_en   = 1'b0;
        cur_data = '0;
        cur_ack  = '0;
    endtask

    // Advances the model over one rising edge given the inputs present at that edge.
    task automatic model_step(input logic [N-1:0] v, input logic f, input logic r);
        int g;
        if (r) begin
            model_reset();
            return;
        end
        if (!cur_en && f && (v != '0)) begin
            g = -1;
            if (PRIO && v[0]) begin
                g = 0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (rr_m + k) % N;
                    if (PRIO && i == 0) continue;
                    if (v[i] && g < 0) g = i;
                end
            end
            if (g >= 0) begin
                exp_q.push_back(lo_d[g]);
                exp_q.push_back(hi_d[g]);
                ack_q.push_back('0);
                ack_q.push_back(4'(1) << g);
                granted[g] = 1'b1;
                if (!(PRIO && g == 0)) rr_m = (g + 1) % N;
            end
        end
        if (exp_q.size() > 0) begin
            cur_en   = 1'b1;
            cur_data = exp_q.pop_front();
            cur_ack  = ack_q.pop_front();
        end else begin
            cur_en   = 1'b0;
            cur_data = '0;
            cur_ack  = '0;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] prime;
        logic [N-1:0] valid;
        logic         full_n;
        int           exp_rr;
        int           exp_prio;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int lat;
        int g;
        int ord_rr[5];
        int ord_p[5];
        logic [N-1:0] pending;

        vecs[0]  = '{4'b0000, 4'b0010, 1'b1,  1,  1};
        vecs[1]  = '{4'b0000, 4'b1111, 1'b1,  0,  0};
        vecs[2]  = '{4'b0001, 4'b1111, 1'b1,  1,  0};
        vecs[3]  = '{4'b0100, 4'b0011, 1'b1,  0,  0};
        vecs[4]  = '{4'b1000, 4'b1000, 1'b1,  3,  3};
        vecs[5]  = '{4'b0010, 4'b0011, 1'b1,  0,  0};
        vecs[6]  = '{4'b0010, 4'b1110, 1'b1,  2,  2};
        vecs[7]  = '{4'b0000, 4'b0000, 1'b1, -1, -1};
        vecs[8]  = '{4'b0000, 4'b1111, 1'b0, -1, -1};
        vecs[9]  = '{4'b0100, 4'b1010, 1'b1,  3,  3};
        vecs[10] = '{4'b0100, 4'b0110, 1'b1,  1,  1};

        for (int i = 0; i < N; i++) begin
            lo_d[i] = W'(64'h0000_1000 + i * 16 + 1);
            hi_d[i] = W'(64'h2AB0_0000_0000 + i * 16 + 2);
        end
        lo_d[1] = W'(1);
        hi_d[1] = W'(2);

        rst             = 1'b1;
        bus.req_valid   = '0;
        bus.fifo_full_n = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset wr_en", 64'(bus.fifo_wr_en),   64'(0));
        check("reset data",  64'(bus.fifo_wr_data), 64'(0));
        check("reset ack",   64'(bus.req_ack),      64'(0));
        check("reset busy",  64'(bus.busy),         64'(0));
        check("reset state", 64'(bus.state_dbg),    64'(0));

        for (int v = 0; v < 11; v++) begin
            string nm;
            int    eg;
            nm = $sformatf("vec%0d", v);
            do_reset();
            if (vecs[v].prime != '0) begin
                g = 0;
                for (int i = 0; i < N; i++) if (vecs[v].prime[i]) g = i;
                bus.req_valid = vecs[v].prime;
                expect_cmd(g, {nm, " prime"}, lat);
                bus.req_valid = '0;
                tick();
            end
            bus.req_valid   = vecs[v].valid;
            bus.fifo_full_n = vecs[v].full_n;
            eg = PRIO ? vecs[v].exp_prio : vecs[v].exp_rr;
            if (eg < 0) begin
                for (int c = 0; c < 4; c++) begin
                    tick();
                    check({nm, " idle_en"}, 64'(bus.fifo_wr_en), 64'(0));
                end
                check({nm, " idle_busy"}, 64'(bus.busy), 64'(0));
            end else begin
                expect_cmd(eg, nm, lat);
                check({nm, " latency"}, 64'(lat), 64'(0));
            end
            bus.req_valid   = '0;
            bus.fifo_full_n = 1'b1;
            tick();
        end

        // All requesters held: pairs back to back with one idle cycle between commands.
        ord_rr = '{0, 1, 2, 3, 0};
        ord_p  = '{0, 0, 0, 0, 0};
        do_reset();
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            expect_cmd(PRIO ? ord_p[k] : ord_rr[k], $sformatf("rr_all%0d", k), lat);
            if (k > 0) check($sformatf("rr_all%0d lat", k), 64'(lat), 64'(0));
            tick();
            check($sformatf("rr_all%0d gap", k), 64'(bus.fifo_wr_en), 64'(0));
        end
        bus.req_valid = '0;
        tick();

        // FIFO full stalls arbitration until full_n rises.
        do_reset();
        bus.fifo_full_n = 1'b0;
        bus.req_valid   = 4'b1000;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("stall wr_en", 64'(bus.fifo_wr_en), 64'(0));
            check("stall busy",  64'(bus.busy),       64'(0));
        end
        bus.fifo_full_n = 1'b1;
        expect_cmd(3, "unstall", lat);
        check("unstall lat", 64'(lat), 64'(0));
        bus.req_valid = '0;
        tick();

        // full_n dropping mid-pair does not stop the high entry.
        do_reset();
        bus.req_valid = 4'b0010;
        tick();
        check("fulldrop lo_en",   64'(bus.fifo_wr_en),   64'(1));
        check("fulldrop lo_data", 64'(bus.fifo_wr_data), 64'(lo_d[1]));
        bus.fifo_full_n = 1'b0;
        tick();
        check("fulldrop hi_en",   64'(bus.fifo_wr_en),   64'(1));
        check("fulldrop hi_data", 64'(bus.fifo_wr_data), 64'(hi_d[1]));
        check("fulldrop ack",     64'(bus.req_ack),      64'(4'b0010));
        bus.req_valid   = '0;
        bus.fifo_full_n = 1'b1;
        tick();

        // Reset during the low entry aborts the pair and leaves rr_ptr at 0.
        do_reset();
        bus.req_valid = 4'b0100;
        tick();
        check("rstmid lo_en", 64'(bus.fifo_wr_en), 64'(1));
        rst = 1'b1;
        tick();
        check("rstmid no_hi",  64'(bus.fifo_wr_en), 64'(0));
        check("rstmid no_ack", 64'(bus.req_ack),    64'(0));
        check("rstmid busy",   64'(bus.busy),       64'(0));
        rst           = 1'b0;
        bus.req_valid = 4'b1111;
        expect_cmd(0, "rstmid after", lat);
        bus.req_valid = '0;
        tick();

`ifdef PCIE_TX_CMD_ARB_PRIO_EN
        do_reset();
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            expect_cmd(0, $sformatf("prio0_%0d", k), lat);
            tick();
        end
        bus.req_valid = 4'b1110;
        ord_rr = '{1, 2, 3, 1, 2};
        for (int k = 0; k < 4; k++) begin
            expect_cmd(ord_rr[k], $sformatf("prio_rest%0d", k), lat);
            tick();
        end
        bus.req_valid = '0;
        tick();
`endif

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        pending = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic         r;
            logic         f;
            check("rnd wr_en", 64'(bus.fifo_wr_en),   64'(cur_en));
            check("rnd data",  64'(bus.fifo_wr_data), 64'(cur_data));
            check("rnd ack",   64'(bus.req_ack),      64'(cur_ack));
            check("rnd busy",  64'(bus.busy),         64'(cur_en));
            for (int i = 0; i < N; i++) begin
                if (cur_ack[i]) begin
                    pending[i] = 1'b0;
                    granted[i] = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!pending[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        pending[i] = 1'b1;
                        lo_d[i]    = W'({$urandom(), $urandom()});
                        hi_d[i]    = W'({$urandom(), $urandom()});
                    end
                end else if (granted[i]) begin
                    lo_d[i] = W'({$urandom(), $urandom()});
                    hi_d[i] = W'({$urandom(), $urandom()});
                end else if ($urandom_range(0, 19) == 0) begin
                    pending[i] = 1'b0;
                end
            end
            r = ($urandom_range(0, 60) == 0);
            f = ($urandom_range(0, 4) != 0);
            rst             = r;
            bus.req_valid   = pending;
            bus.fifo_full_n = f;
            model_step(pending, f, r);
            tick();
        end
        rst           = 1'b0;
        bus.req_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
